tl_fc_credit_gate: RTL and testbench

//  Transmit-side flow-control credit gate of the transaction layer, successor to the fixed-width credit vector.

---
 rtl/tl_pkg.sv | 29 ++
 rtl/tl_fc_credit_slot.sv | 58 +++++
 rtl/tl_fc_credit_gate.sv | 156 +++++++++++++++
 tb/tb_tl_fc_credit_gate.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions used by the flow-control credit gate.
//   tl_fc_type_e    : credit class of a TLP / FC DLLP (posted, non-posted, completion)
//   tl_fc_state_e   : credit gate initialisation state
//   TL_FC_CREDIT_DW : payload DWs covered by one data credit
//   fc_data_credits : data credits needed for a payload length (0 encodes 1024 DW)
package tl_pkg;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } tl_fc_type_e;

  typedef enum logic {
    FC_INIT   = 1'b0,
    FC_ACTIVE = 1'b1
  } tl_fc_state_e;

  localparam int TL_FC_CREDIT_DW = 4;
  localparam int TL_FC_NUM_TYPES = 3;

  // ceil(len / 4); a length field of 0 means the 1024 DW maximum (256 credits).
  function automatic logic [8:0] fc_data_credits(input logic [9:0] len_dw);
    logic [10:0] dw;
    dw = (len_dw == 10'd0) ? 11'd1024 : {1'b0, len_dw};
    return 9'((dw + 11'(TL_FC_CREDIT_DW - 1)) / 11'(TL_FC_CREDIT_DW));
  endfunction

endpackage

// File: rtl/tl_fc_credit_slot.sv
// One flow-control credit counter pair (credit limit CL, credits consumed CC)
// plus an infinite-credit flag, with the modulo-2^W sufficiency compare.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   init_load   : InitFC for this slot; loads CL, field 0 marks the credit infinite
//   upd_load    : UpdateFC for this slot; overwrites CL unless infinite
//   fc_field    : advertised credit field of the DLLP
//   consume     : TLP granted; CC += need
//   need        : credits the current request needs from this slot
//   sufficient  : combinational, enough credit for 'need'
//   upd_err     : combinational, nonzero UpdateFC on an infinite credit
module tl_fc_credit_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_load,
  input  logic         upd_load,
  input  logic [W-1:0] fc_field,
  input  logic         consume,
  input  logic [W-1:0] need,
  output logic         sufficient,
  output logic         upd_err
);

  localparam logic [W-1:0] HALF = W'(1) << (W - 1);

  logic [W-1:0] cl_reg;
  logic [W-1:0] cc_reg;
  logic         inf_reg;
  logic [W-1:0] headroom;

  // Modular headroom: anything that lands in the upper half means the limit
  // would be overrun, since CL never legitimately leads CC by more than half.
  assign headroom   = cl_reg - (cc_reg + need);
  assign sufficient = inf_reg || (headroom <= HALF);
  assign upd_err    = upd_load && inf_reg && (fc_field != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cl_reg  <= '0;
      cc_reg  <= '0;
      inf_reg <= 1'b0;
    end else begin
      if (init_load) begin
        cl_reg  <= fc_field;
        inf_reg <= (fc_field == '0);
      end else if (upd_load && !inf_reg) begin
        cl_reg <= fc_field;
      end
      // Infinite credits are never accounted, so CC stays frozen.
      if (consume && !inf_reg) begin
        cc_reg <= cc_reg + need;
      end
    end
  end

endmodule

// File: rtl/tl_fc_credit_gate.sv
// Transmit-side flow-control credit gate. Tracks CL/CC for PH/PD/NPH/NPD/CPLH/CPLD,
// loads limits from InitFC/UpdateFC DLLPs and grants TLPs only when both the
// header and data credits of the request's type suffice.
// Optional feature macro: TL_FC_STATS_EN adds per-type stall counters (stall_cnt).
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   fc_upd_*       : decoded FC DLLP (valid, init=InitFC, type 0=P 1=NP 2=CPL, hdr/data fields)
//   req_*          : TLP request (valid, type, has_data, length in DW with 0 = 1024)
//   req_ready      : grant, combinational from registered credit state and req_*
//   fc_ready       : all three InitFC types seen
//   fc_err         : one-cycle pulse on an illegal FC type or nonzero UpdateFC on infinite credit
//   stall_cnt      : saturating blocked-cycle counters {CPL,NP,P} (TL_FC_STATS_EN only)
module tl_fc_credit_gate
  import tl_pkg::*;
#(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fc_upd_valid,
  input  logic              fc_upd_init,
  input  logic [1:0]        fc_upd_type,
  input  logic [HDR_W-1:0]  fc_upd_hdr,
  input  logic [DATA_W-1:0] fc_upd_data,
  input  logic              req_valid,
  input  logic [1:0]        req_type,
  input  logic              req_has_data,
  input  logic [9:0]        req_len_dw,
  output logic              req_ready,
  output logic              fc_ready,
  output logic              fc_err
`ifdef TL_FC_STATS_EN
  ,
  output logic [3*STAT_W-1:0] stall_cnt
`endif
);

  // DATA_W below 9 could not hold the 256-credit need of a maximum payload.
  if (HDR_W < 2 || DATA_W < 9 || STAT_W < 1) begin : g_param_check
    $error("tl_fc_credit_gate: unsupported counter widths");
  end

  tl_fc_state_e      state_reg;
  logic [2:0]        mask_reg;
  logic [2:0]        mask_next;
  logic              fc_ready_reg;
  logic              fc_err_reg;
  logic              fc_err_next;

  logic [2:0]        init_load;
  logic [2:0]        upd_load;
  logic [2:0]        consume;
  logic [2:0]        hdr_err;
  logic [2:0]        data_err;
  // Bit 3 stands for the illegal request type and is never sufficient.
  logic [3:0]        hdr_ok;
  logic [3:0]        data_ok;

  logic [HDR_W-1:0]  hdr_need;
  logic [DATA_W-1:0] data_need;
  logic              grant;

  assign hdr_need  = HDR_W'(1);
  assign data_need = req_has_data ? DATA_W'(fc_data_credits(req_len_dw)) : '0;

  assign hdr_ok[3]  = 1'b0;
  assign data_ok[3] = 1'b0;

  assign req_ready = fc_ready_reg && hdr_ok[req_type] && data_ok[req_type];
  assign grant     = req_valid && req_ready;

  genvar gi;
  for (gi = 0; gi < TL_FC_NUM_TYPES; gi++) begin : g_type
    logic upd_sel;
    assign upd_sel       = fc_upd_valid && (fc_upd_type == 2'(gi));
    // InitFC is only honoured while initialising, UpdateFC only once active.
    assign init_load[gi] = upd_sel && fc_upd_init && (state_reg == FC_INIT);
    assign upd_load[gi]  = upd_sel && !fc_upd_init && (state_reg == FC_ACTIVE);
    assign consume[gi]   = grant && (req_type == 2'(gi));

    tl_fc_credit_slot #(.W(HDR_W)) u_hdr (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_load  (init_load[gi]),
      .upd_load   (upd_load[gi]),
      .fc_field   (fc_upd_hdr),
      .consume    (consume[gi]),
      .need       (hdr_need),
      .sufficient (hdr_ok[gi]),
      .upd_err    (hdr_err[gi])
    );

    tl_fc_credit_slot #(.W(DATA_W)) u_data (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_load  (init_load[gi]),
      .upd_load   (upd_load[gi]),
      .fc_field   (fc_upd_data),
      .consume    (consume[gi]),
      .need       (data_need),
      .sufficient (data_ok[gi]),
      .upd_err    (data_err[gi])
    );
  end

  assign mask_next   = mask_reg | init_load;
  assign fc_err_next = (fc_upd_valid && (fc_upd_type == 2'd3)) || (|hdr_err) || (|data_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= FC_INIT;
      mask_reg     <= 3'b000;
      fc_ready_reg <= 1'b0;
      fc_err_reg   <= 1'b0;
    end else begin
      fc_err_reg <= fc_err_next;
      case (state_reg)
        FC_INIT: begin
          mask_reg <= mask_next;
          if (mask_next == 3'b111) begin
            state_reg    <= FC_ACTIVE;
            fc_ready_reg <= 1'b1;
          end
        end
        FC_ACTIVE: begin
          fc_ready_reg <= 1'b1;
        end
        default: begin
          state_reg    <= FC_INIT;
          fc_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign fc_ready = fc_ready_reg;
  assign fc_err   = fc_err_reg;

`ifdef TL_FC_STATS_EN
  for (gi = 0; gi < TL_FC_NUM_TYPES; gi++) begin : g_stats
    logic [STAT_W-1:0] stall_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stall_reg <= '0;
      end else if (req_valid && !req_ready && fc_ready_reg &&
                   (req_type == 2'(gi)) && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end
    assign stall_cnt[gi*STAT_W +: STAT_W] = stall_reg;
  end
`endif

endmodule

// File: tb/tb_tl_fc_credit_gate.sv
// Directed bench for tl_fc_credit_gate: a table of per-cycle vectors for
// init, exhaustion, same-cycle update and error pulses, then hand-written
// sequences for mid-stream reset, the 12-bit data counter wrap and stats.
module tb_tl_fc_credit_gate;

  localparam int HDR_W  = 8;
  localparam int DATA_W = 12;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fc_upd_valid = 1'b0;
  logic              fc_upd_init = 1'b0;
  logic [1:0]        fc_upd_type = 2'd0;
  logic [HDR_W-1:0]  fc_upd_hdr = '0;
  logic [DATA_W-1:0] fc_upd_data = '0;
  logic              req_valid = 1'b0;
  logic [1:0]        req_type = 2'd0;
  logic              req_has_data = 1'b0;
  logic [9:0]        req_len_dw = '0;
  logic              req_ready;
  logic              fc_ready;
  logic              fc_err;
`ifdef TL_FC_STATS_EN
  logic [3*STAT_W-1:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tl_fc_credit_gate #(.HDR_W(HDR_W), .DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fc_upd_valid (fc_upd_valid),
    .fc_upd_init  (fc_upd_init),
    .fc_upd_type  (fc_upd_type),
    .fc_upd_hdr   (fc_upd_hdr),
    .fc_upd_data  (fc_upd_data),
    .req_valid    (req_valid),
    .req_type     (req_type),
    .req_has_data (req_has_data),
    .req_len_dw   (req_len_dw),
    .req_ready    (req_ready),
    .fc_ready     (fc_ready),
    .fc_err       (fc_err)
`ifdef TL_FC_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          uv;
    bit          ui;
    logic [1:0]  ut;
    logic [7:0]  uh;
    logic [11:0] ud;
    bit          rv;
    logic [1:0]  rt;
    bit          hd;
    logic [9:0]  len;
    bit          er;   // expected req_ready
    bit          efr;  // expected fc_ready
    bit          ee;   // expected fc_err
  } vec_t;

  function automatic vec_t mk(input string name,
                              input bit uv, input bit ui, input logic [1:0] ut,
                              input logic [7:0] uh, input logic [11:0] ud,
                              input bit rv, input logic [1:0] rt, input bit hd,
                              input logic [9:0] len,
                              input bit er, input bit efr, input bit ee);
    vec_t v;
    v.name = name; v.uv = uv; v.ui = ui; v.ut = ut; v.uh = uh; v.ud = ud;
    v.rv = rv; v.rt = rt; v.hd = hd; v.len = len;
    v.er = er; v.efr = efr; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, sample just after.
  task automatic apply(input vec_t v);
    @(negedge clk);
    fc_upd_valid = v.uv; fc_upd_init = v.ui; fc_upd_type = v.ut;
    fc_upd_hdr = v.uh; fc_upd_data = v.ud;
    req_valid = v.rv; req_type = v.rt; req_has_data = v.hd; req_len_dw = v.len;
    #1;
    check({v.name, ".req_ready"}, 32'(req_ready), 32'(v.er));
    check({v.name, ".fc_ready"}, 32'(fc_ready), 32'(v.efr));
    check({v.name, ".fc_err"}, 32'(fc_err), 32'(v.ee));
    $display("vec %-16s upd=%0d/%0d/%0d(%0d,%0d) req=%0d/%0d/%0d/%0d -> ready=%0d fc_ready=%0d err=%0d",
             v.name, v.uv, v.ui, v.ut, v.uh, v.ud, v.rv, v.rt, v.hd, v.len,
             req_ready, fc_ready, fc_err);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    fc_upd_valid = 1'b0; fc_upd_init = 1'b0; fc_upd_type = 2'd0;
    fc_upd_hdr = '0; fc_upd_data = '0;
    req_valid = 1'b0; req_type = 2'd0; req_has_data = 1'b1; req_len_dw = 10'd16;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({nm, ".req_ready"}, 32'(req_ready), 32'd0);
    check({nm, ".fc_ready"}, 32'(fc_ready), 32'd0);
    check({nm, ".fc_err"}, 32'(fc_err), 32'd0);
    $display("reset %s: ready=%0d fc_ready=%0d err=%0d", nm, req_ready, fc_ready, fc_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[28];

  initial begin
    // name, uv ui ut uh ud, rv rt hd len, ready fc_ready err
    // InitFC P=(4,16) NP=(2,0) CPL=(0,0); fc_ready the cycle after the third.
    tbl[0]  = mk("init_p",        1,1,0,4,16,  0,0,0,0,   0,0,0);
    tbl[1]  = mk("init_np",       1,1,1,2,0,   0,0,0,0,   0,0,0);
    tbl[2]  = mk("init_cpl",      1,1,2,0,0,   0,0,0,0,   0,0,0);
    tbl[3]  = mk("p_probe",       0,0,0,0,0,   0,0,1,16,  1,1,0);
    tbl[4]  = mk("np_data_inf",   0,0,0,0,0,   0,1,1,0,   1,1,0);
    tbl[5]  = mk("cpl_inf",       0,0,0,0,0,   0,2,1,0,   1,1,0);
    // Four P writes of 16 DW use PH 4 / PD 16; the fifth is blocked.
    tbl[6]  = mk("p_wr1",         0,0,0,0,0,   1,0,1,16,  1,1,0);
    tbl[7]  = mk("p_wr2",         0,0,0,0,0,   1,0,1,16,  1,1,0);
    tbl[8]  = mk("p_wr3",         0,0,0,0,0,   1,0,1,16,  1,1,0);
    tbl[9]  = mk("p_wr4",         0,0,0,0,0,   1,0,1,16,  1,1,0);
    tbl[10] = mk("p_wr5_blk",     0,0,0,0,0,   1,0,1,16,  0,1,0);
    // Same-cycle UpdateFC is judged against the old limit.
    tbl[11] = mk("p_upd_same",    1,0,0,8,32,  1,0,1,16,  0,1,0);
    tbl[12] = mk("p_wr_after",    0,0,0,0,0,   1,0,1,16,  1,1,0);
    tbl[13] = mk("p_nodata",      0,0,0,0,0,   1,0,0,16,  1,1,0);
    tbl[14] = mk("req_type3",     0,0,0,0,0,   0,3,0,0,   0,1,0);
    // PD CL 32 CC 20; 64 DW needs 16 -> blocked until UpdateFC 48 lands.
    tbl[15] = mk("pd_upd_same",   1,0,0,8,48,  1,0,1,64,  0,1,0);
    tbl[16] = mk("pd_after_upd",  0,0,0,0,0,   1,0,1,64,  1,1,0);
    // Illegal FC type: pulse one cycle later, one cycle wide.
    tbl[17] = mk("upd_type3",     1,0,3,1,1,   0,0,0,0,   1,1,0);
    tbl[18] = mk("err_pulse",     0,0,0,0,0,   0,0,0,0,   1,1,1);
    tbl[19] = mk("err_clear",     0,0,0,0,0,   0,0,0,0,   1,1,0);
    // Nonzero UpdateFC on infinite credits: error, credit stays infinite.
    tbl[20] = mk("cpl_inf_upd",   1,0,2,5,0,   0,0,0,0,   1,1,0);
    tbl[21] = mk("cpl_still_inf", 0,0,0,0,0,   0,2,1,0,   1,1,1);
    tbl[22] = mk("np_inf_upd",    1,0,1,3,7,   0,2,1,0,   1,1,0);
    tbl[23] = mk("np_data_inf2",  0,0,0,0,0,   0,1,1,0,   1,1,1);
    // InitFC while active is ignored: PH stays 8, CC 7 -> exactly one left.
    tbl[24] = mk("init_ignored",  1,1,0,1,1,   0,0,0,0,   1,1,0);
    tbl[25] = mk("p_hdr_last",    0,0,0,0,0,   1,0,0,0,   1,1,0);
    tbl[26] = mk("p_hdr_empty",   0,0,0,0,0,   1,0,0,0,   0,1,0);
    tbl[27] = mk("np_hdr_ok",     0,0,0,0,0,   0,1,0,0,   1,1,0);

    do_reset("reset0");
    for (int i = 0; i < 28; i++) apply(tbl[i]);

    // Reset mid-stream: a ready request the cycle reset is asserted,
    // nothing ready and fc_ready low the cycle after.
    @(negedge clk);
    rst_n = 1'b0;
    fc_upd_valid = 1'b0; req_valid = 1'b1; req_type = 2'd1; req_has_data = 1'b0; req_len_dw = 10'd0;
    #1;
    check("midrst.pre_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.req_ready", 32'(req_ready), 32'd0);
    check("midrst.fc_ready", 32'(fc_ready), 32'd0);
    $display("midrst: ready=%0d fc_ready=%0d", req_ready, fc_ready);

    // UpdateFC before init and two InitFCs do not make the gate ready.
    apply(mk("rst_upd_ign",   1,0,0,4,16,   0,0,0,0, 0,0,0));
    apply(mk("reinit_np",     1,1,1,1,1,    0,0,0,0, 0,0,0));
    apply(mk("reinit_cpl",    1,1,2,1,1,    0,0,0,0, 0,0,0));
    apply(mk("mask_partial",  0,0,0,0,0,    0,0,0,0, 0,0,0));
    // PH infinite, PD 2000; stepped up so CC legitimately reaches 4080.
    apply(mk("reinit_p",      1,1,0,0,2000, 0,0,0,0, 0,0,0));
    for (int i = 0; i < 7; i++) apply(mk("big_wr_a", 0,0,0,0,0, 1,0,1,0, 1,1,0));
    apply(mk("upd_3800",      1,0,0,0,3800, 0,0,0,0, 1,1,0));
    for (int i = 0; i < 7; i++) apply(mk("big_wr_b", 0,0,0,0,0, 1,0,1,0, 1,1,0));
    apply(mk("upd_4090",      1,0,0,0,4090, 0,0,0,0, 1,1,0));
    apply(mk("wr_256",        0,0,0,0,0,    1,0,1,0,   1,1,0));   // CC 3840
    apply(mk("wr_240",        0,0,0,0,0,    1,0,1,960, 1,1,0));   // CC 4080
    apply(mk("wr_wrap_blk",   0,0,0,0,0,    1,0,1,64,  0,1,0));   // needs 16, 10 left
    apply(mk("upd_wrap_same", 1,0,0,0,10,   1,0,1,64,  0,1,0));   // CL 4106 mod 4096
    apply(mk("wr_wrap",       0,0,0,0,0,    1,0,1,64,  1,1,0));   // CC wraps to 0
    apply(mk("cc0_fit",       0,0,0,0,0,    0,0,1,40,  1,1,0));   // 10 of 10
    apply(mk("cc0_over",      0,0,0,0,0,    0,0,1,44,  0,1,0));   // 11 of 10

`ifdef TL_FC_STATS_EN
    do_reset("reset_stats");
    apply(mk("st_init_p",   1,1,0,1,1, 0,0,0,0, 0,0,0));
    apply(mk("st_init_np",  1,1,1,1,1, 0,0,0,0, 0,0,0));
    apply(mk("st_init_cpl", 1,1,2,1,1, 0,0,0,0, 0,0,0));
    for (int i = 0; i < 10; i++) apply(mk("st_blk_p", 0,0,0,0,0, 1,0,1,8, 0,1,0));
    apply(mk("st_idle", 0,0,0,0,0, 0,0,0,0, 1,1,0));
    check("stall_p",   32'(stall_cnt[0*STAT_W +: STAT_W]), 32'd10);
    check("stall_np",  32'(stall_cnt[1*STAT_W +: STAT_W]), 32'd0);
    check("stall_cpl", 32'(stall_cnt[2*STAT_W +: STAT_W]), 32'd0);
    $display("stats: p=%0d np=%0d cpl=%0d", stall_cnt[0 +: STAT_W],
             stall_cnt[STAT_W +: STAT_W], stall_cnt[2*STAT_W +: STAT_W]);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
